// File: rtl/track_gesture_filter_pkg.sv
// Shared types and constants for the centroid gesture filter: FSM encoding,
// the no-match sentinel, default frame size and the dwell distance helper.
package track_gesture_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_STAMPED = 2'd2,
    ST_COAST   = 2'd3
  } state_e;

  localparam logic [31:0] NOT_FOUND     = 32'hFFFF_FFFF;
  localparam int          X_MAX_DEFAULT = 640;
  localparam int          Y_MAX_DEFAULT = 480;

  // |a - b| on 11-bit values; operands are pixel coordinates, so the
  // difference never reaches -1024 and the negation cannot overflow.
  function automatic logic [10:0] abs_diff11(input logic [10:0] a, input logic [10:0] b);
    logic signed [10:0] d;
    d = $signed(a) - $signed(b);
    return d[10] ? 11'(-d) : 11'(d);
  endfunction

endpackage

// File: rtl/track_gesture_filter_ema.sv
// One axis of the exponential centroid filter: filt += (raw - filt) >>> SHIFT,
// with a direct load used when a new object is acquired.
module track_ema #(
  parameter int WIDTH = 10,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             update,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] filt
);

  logic signed [WIDTH:0]   w_diff;
  logic        [WIDTH-1:0] w_step;

  // The step always lands between filt and raw, so modulo-WIDTH addition of
  // the sign-extended step is exact.
  assign w_diff = $signed({1'b0, raw}) - $signed({1'b0, filt});
  assign w_step = WIDTH'(w_diff >>> SHIFT);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= '0;
    end else if (load) begin
      filt <= raw;
    end else if (update) begin
      filt <= filt + w_step;
    end
  end

endmodule

// File: rtl/track_gesture_filter.sv
// Per-frame centroid post-processing: hit/miss classification, EMA smoothing,
// dropout coasting and dwell detection with a one-cycle stamp pulse.
module track_gesture_filter
  import track_gesture_filter_pkg::*;
#(
  parameter int FILT_SHIFT   = 2,
  parameter int DWELL_RADIUS = 8,
  parameter int DWELL_FRAMES = 30,
  parameter int LOST_FRAMES  = 3,
  parameter int X_MAX        = X_MAX_DEFAULT,
  parameter int Y_MAX        = Y_MAX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pos_valid,
  input  logic [31:0]              x_pos,
  input  logic [31:0]              y_pos,
  output logic                     out_valid,
  output logic                     present,
  output logic [$clog2(X_MAX)-1:0] x_filt,
  output logic [$clog2(Y_MAX)-1:0] y_filt,
  output logic                     stamp,
  output logic [1:0]               state
);

  localparam int XW  = $clog2(X_MAX);
  localparam int YW  = $clog2(Y_MAX);
  localparam int DCW = $clog2(DWELL_FRAMES + 1);
  localparam int MCW = $clog2(LOST_FRAMES + 1);

  state_e           r_state;
  logic [DCW-1:0]   r_dwell;
  logic [MCW-1:0]   r_miss;
  logic [XW-1:0]    r_anchor_x;
  logic [YW-1:0]    r_anchor_y;

  state_e           w_state_nx;
  logic [DCW-1:0]   w_dwell_nx;
  logic [MCW-1:0]   w_miss_nx;
  logic [XW-1:0]    w_anchor_x_nx;
  logic [YW-1:0]    w_anchor_y_nx;
  logic             w_present_nx;
  logic             w_stamp_nx;
  logic             w_load;
  logic             w_update;

  logic             w_hit;
  logic             w_near;
  logic [XW-1:0]    w_raw_x;
  logic [YW-1:0]    w_raw_y;

  assign w_hit   = (x_pos != NOT_FOUND) && (x_pos < 32'(X_MAX)) && (y_pos < 32'(Y_MAX));
  assign w_raw_x = x_pos[XW-1:0];
  assign w_raw_y = y_pos[YW-1:0];
  assign w_near  = (abs_diff11(11'(w_raw_x), 11'(r_anchor_x)) <= 11'(DWELL_RADIUS)) &&
                   (abs_diff11(11'(w_raw_y), 11'(r_anchor_y)) <= 11'(DWELL_RADIUS));
  assign state   = r_state;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nx    = r_state;
    w_dwell_nx    = r_dwell;
    w_miss_nx     = r_miss;
    w_anchor_x_nx = r_anchor_x;
    w_anchor_y_nx = r_anchor_y;
    w_present_nx  = present;
    w_stamp_nx    = 1'b0;
    w_load        = 1'b0;
    w_update      = 1'b0;

    if (pos_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            w_load        = 1'b1;
            w_anchor_x_nx = w_raw_x;
            w_anchor_y_nx = w_raw_y;
            w_dwell_nx    = DCW'(1);
            w_present_nx  = 1'b1;
            if (DWELL_FRAMES == 1) begin
              w_stamp_nx = 1'b1;
              w_state_nx = ST_STAMPED;
            end else begin
              w_state_nx = ST_TRACK;
            end
          end
        end

        ST_TRACK, ST_STAMPED: begin
          if (!w_hit) begin
            w_miss_nx  = MCW'(1);
            w_dwell_nx = '0;
            w_state_nx = ST_COAST;
          end else begin
            w_update = 1'b1;
            if (!w_near) begin
              w_anchor_x_nx = w_raw_x;
              w_anchor_y_nx = w_raw_y;
              w_dwell_nx    = DCW'(1);
              w_state_nx    = ST_TRACK;
            end else if (r_state == ST_TRACK) begin
              // Reaching the threshold stamps once; STAMPED suppresses repeats.
              if (r_dwell >= DCW'(DWELL_FRAMES - 1)) begin
                w_dwell_nx = DCW'(DWELL_FRAMES);
                w_stamp_nx = 1'b1;
                w_state_nx = ST_STAMPED;
              end else begin
                w_dwell_nx = r_dwell + DCW'(1);
              end
            end
          end
        end

        ST_COAST: begin
          if (w_hit) begin
            w_miss_nx     = '0;
            w_update      = 1'b1;
            w_anchor_x_nx = w_raw_x;
            w_anchor_y_nx = w_raw_y;
            w_dwell_nx    = DCW'(1);
            w_state_nx    = ST_TRACK;
          end else if (r_miss >= MCW'(LOST_FRAMES - 1)) begin
            w_miss_nx    = MCW'(LOST_FRAMES);
            w_present_nx = 1'b0;
            w_state_nx   = ST_IDLE;
          end else begin
            w_miss_nx = r_miss + MCW'(1);
          end
        end

        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_dwell    <= '0;
      r_miss     <= '0;
      r_anchor_x <= '0;
      r_anchor_y <= '0;
      out_valid  <= 1'b0;
      present    <= 1'b0;
      stamp      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_dwell    <= w_dwell_nx;
      r_miss     <= w_miss_nx;
      r_anchor_x <= w_anchor_x_nx;
      r_anchor_y <= w_anchor_y_nx;
      out_valid  <= pos_valid;
      present    <= w_present_nx;
      stamp      <= w_stamp_nx;
    end
  end

  track_ema #(
    .WIDTH (XW),
    .SHIFT (FILT_SHIFT)
  ) u_ema_x (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .update (w_update),
    .raw    (w_raw_x),
    .filt   (x_filt)
  );

  track_ema #(
    .WIDTH (YW),
    .SHIFT (FILT_SHIFT)
  ) u_ema_y (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .update (w_update),
    .raw    (w_raw_y),
    .filt   (y_filt)
  );

endmodule

// File: tb/tb_track_gesture_filter.sv
// Directed bench for track_gesture_filter: reset, first hit, EMA, dwell/stamp,
// dropout coasting, loss and reset during dwell.
module tb_track_gesture_filter;
  import track_gesture_filter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pos_valid = 1'b0;
  logic [31:0] x_pos = NOT_FOUND;
  logic [31:0] y_pos = NOT_FOUND;
  logic        out_valid, present, stamp;
  logic [9:0]  x_filt;
  logic [8:0]  y_filt;
  logic [1:0]  state;

  logic [23:0] obs;
  logic [23:0] exp_v;
  int checks = 0;
  int errors = 0;
  int ex = 0;
  int ey = 0;

  always #5 clk = ~clk;

  track_gesture_filter dut (
    .clk       (clk),
    .reset     (reset),
    .pos_valid (pos_valid),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .out_valid (out_valid),
    .present   (present),
    .x_filt    (x_filt),
    .y_filt    (y_filt),
    .stamp     (stamp),
    .state     (state)
  );

  assign obs = {out_valid, present, stamp, state, x_filt, y_filt};

  // Reference EMA with weight 1/4: f + floor((r - f) / 4).
  function automatic int ema(input int f, input int r);
    int d;
    d = r - f;
    return f + ((d >= 0) ? (d / 4) : -((-d + 3) / 4));
  endfunction

  function automatic logic [23:0] pack(input logic ov, input logic pr, input logic st,
                                       input logic [1:0] s, input int x, input int y);
    return {ov, pr, st, s, 10'(x), 9'(y)};
  endfunction

  // Called at a falling edge; returns at the next falling edge with out_valid live.
  task automatic strobe(input logic [31:0] x, input logic [31:0] y);
    pos_valid = 1'b1;
    x_pos     = x;
    y_pos     = y;
    @(negedge clk);
    pos_valid = 1'b0;
    x_pos     = NOT_FOUND;
    y_pos     = NOT_FOUND;
  endtask

  task automatic test_reset;
    pos_valid = 1'b1;
    x_pos     = 32'd10;
    y_pos     = 32'd10;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 24'd0) begin
      errors++;
      $display("FAIL reset_hold got %h expected %h", obs, 24'd0);
    end
    pos_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 24'd0) begin
      errors++;
      $display("FAIL reset_release got %h expected %h", obs, 24'd0);
    end
  endtask

  task automatic test_first_hit;
    strobe(32'd100, 32'd200);
    ex = 100; ey = 200;
    exp_v = pack(1'b1, 1'b1, 1'b0, 2'd1, ex, ey);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL first_hit got %h expected %h", obs, exp_v);
    end
    strobe(32'd120, 32'd200);
    ex = ema(ex, 120); ey = ema(ey, 200);
    exp_v = pack(1'b1, 1'b1, 1'b0, 2'd1, 105, 200);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ema_step got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = pack(1'b0, 1'b1, 1'b0, 2'd1, 105, 200);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL idle_hold got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_dwell;
    int x, y;
    for (int i = 0; i < 30; i++) begin
      x = 300 + (i % 7) - 3;
      y = 300 + ((i * 3) % 7) - 3;
      strobe(32'(x), 32'(y));
      ex = ema(ex, x); ey = ema(ey, y);
      exp_v = pack(1'b1, 1'b1, (i == 29), (i == 29) ? 2'd2 : 2'd1, ex, ey);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL dwell[%0d] got %h expected %h", i, obs, exp_v);
      end
    end
    strobe(32'(x), 32'(y));
    ex = ema(ex, x); ey = ema(ey, y);
    exp_v = pack(1'b1, 1'b1, 1'b0, 2'd2, ex, ey);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL dwell_no_restamp got %h expected %h", obs, exp_v);
    end
    strobe(32'd320, 32'd300);
    ex = ema(ex, 320); ey = ema(ey, 300);
    exp_v = pack(1'b1, 1'b1, 1'b0, 2'd1, ex, ey);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL dwell_move got %h expected %h", obs, exp_v);
    end
  endtask

  // Consecutive-cycle strobes: the move above counts as frame 1, so 29 more stamp.
  task automatic test_back_to_back;
    for (int i = 0; i < 29; i++) begin
      strobe(32'd320, 32'd300);
      ex = ema(ex, 320); ey = ema(ey, 300);
      exp_v = pack(1'b1, 1'b1, (i == 28), (i == 28) ? 2'd2 : 2'd1, ex, ey);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b[%0d] got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_dropout;
    for (int i = 0; i < 2; i++) begin
      strobe(NOT_FOUND, NOT_FOUND);
      exp_v = pack(1'b1, 1'b1, 1'b0, 2'd3, ex, ey);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL coast[%0d] got %h expected %h", i, obs, exp_v);
      end
    end
    strobe(32'd300, 32'd300);
    ex = ema(ex, 300); ey = ema(ey, 300);
    exp_v = pack(1'b1, 1'b1, 1'b0, 2'd1, ex, ey);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reacquire got %h expected %h", obs, exp_v);
    end
    checks++;
    if (x_filt === 10'd300) begin
      errors++;
      $display("FAIL reacquire_no_reload got %0d expected not 300", x_filt);
    end
  endtask

  task automatic test_loss;
    logic [31:0] mx [3];
    logic [31:0] my [3];
    mx = '{NOT_FOUND, 32'd700, 32'd100};
    my = '{NOT_FOUND, 32'd100, 32'd480};
    for (int i = 0; i < 3; i++) begin
      strobe(mx[i], my[i]);
      exp_v = pack(1'b1, (i != 2), 1'b0, (i == 2) ? 2'd0 : 2'd3, ex, ey);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL loss[%0d] got %h expected %h", i, obs, exp_v);
      end
    end
    strobe(NOT_FOUND, NOT_FOUND);
    exp_v = pack(1'b1, 1'b0, 1'b0, 2'd0, ex, ey);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL idle_miss got %h expected %h", obs, exp_v);
    end
    strobe(32'd50, 32'd60);
    ex = 50; ey = 60;
    exp_v = pack(1'b1, 1'b1, 1'b0, 2'd1, ex, ey);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reload got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_dwell;
    for (int i = 0; i < 20; i++) begin
      strobe(32'd200, 32'd200);
      ex = ema(ex, 200); ey = ema(ey, 200);
    end
    exp_v = pack(1'b1, 1'b1, 1'b0, 2'd1, ex, ey);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pre_reset got %h expected %h", obs, exp_v);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 24'd0) begin
      errors++;
      $display("FAIL async_reset got %h expected %h", obs, 24'd0);
    end
    pos_valid = 1'b1;
    x_pos     = 32'd200;
    y_pos     = 32'd200;
    @(negedge clk);
    checks++;
    if (obs !== 24'd0) begin
      errors++;
      $display("FAIL strobe_in_reset got %h expected %h", obs, 24'd0);
    end
    pos_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    ex = 200; ey = 200;
    for (int i = 0; i < 30; i++) begin
      strobe(32'd200, 32'd200);
      exp_v = pack(1'b1, 1'b1, (i == 29), (i == 29) ? 2'd2 : 2'd1, ex, ey);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL post_reset_dwell[%0d] got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_dwell();
    test_back_to_back();
    test_dropout();
    test_loss();
    test_reset_mid_dwell();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/track_gesture_filter.md
Name: track_gesture_filter

Overview:
- Downstream of the colour-tracking datapath. Consumes one centroid per frame (x_pos/y_pos; 32'hFFFFFFFF means no match).
- Smooths the centroid with an exponential filter, tolerates short dropouts and detects dwell.
- Dwell is the pen held still, and it produces a one-cycle stamp pulse for the drag-and-stamp application.
- All outputs are registered for the AXI register bank and the draw engine.

Parameters:
- FILT_SHIFT, 2, EMA weight: filt += (raw - filt) >>> FILT_SHIFT
- DWELL_RADIUS, 8, max per-axis |raw - anchor| (pixels) still counted as stationary
- DWELL_FRAMES, 30, consecutive stationary frames, anchor frame included, needed to stamp
- LOST_FRAMES, 3, consecutive misses before the object is declared lost
- X_MAX, 640, frame width; valid x is 0..X_MAX-1
- Y_MAX, 480, frame height; valid y is 0..Y_MAX-1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pos_valid  in  1  one-cycle strobe; x_pos/y_pos are valid this cycle (once per frame)
- x_pos  in  32  raw centroid x, or 32'hFFFFFFFF
- y_pos  in  32  raw centroid y, or 32'hFFFFFFFF
- out_valid  out  1  one-cycle pulse; outputs updated for this frame
- present  out  1  object currently tracked
- x_filt  out  10  filtered x
- y_filt  out  9  filtered y
- stamp  out  1  one-cycle pulse coincident with out_valid when dwell completes
- state  out  2  FSM state, for debug/status register

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All outputs, counters, anchor and filter registers go to 0. State = IDLE.
  - Reset mid-operation discards any dwell/loss progress.
  - A pos_valid coincident with reset is ignored.
- Hit/miss classification, per strobe:
  - hit = (x_pos < X_MAX) && (y_pos < Y_MAX).
  - Anything else is a miss, including 32'hFFFFFFFF and out-of-range values such as 700.
- Latency:
  - Every strobe produces out_valid exactly 1 cycle later. Outputs change only in that same cycle.
  - Without a strobe, all outputs hold and out_valid/stamp stay 0.
  - Back-to-back strobes (consecutive cycles) are each processed.
- FSM states: IDLE=0, TRACK=1, STAMPED=2, COAST=3.
- IDLE:
  - hit: filt <= raw (direct load, no averaging), anchor <= raw, dwell_cnt <= 1, present <= 1, go to TRACK. If DWELL_FRAMES==1, stamp and go to STAMPED instead.
  - miss: stay in IDLE.
- TRACK, on a hit:
  - Update the EMA.
  - If both |raw - anchor| <= DWELL_RADIUS: dwell_cnt++. When it reaches DWELL_FRAMES, stamp=1 and go to STAMPED.
  - Otherwise: anchor <= raw, dwell_cnt <= 1.
- STAMPED, on a hit:
  - Update the EMA. No further stamps.
  - If either axis exceeds DWELL_RADIUS from anchor: anchor <= raw, dwell_cnt <= 1, go to TRACK.
- TRACK or STAMPED, on a miss:
  - miss_cnt <= 1, dwell_cnt <= 0, go to COAST. Filter holds and present stays 1.
- COAST:
  - miss: miss_cnt++. When it reaches LOST_FRAMES, present <= 0, go to IDLE. x_filt/y_filt hold their last value.
  - hit: miss_cnt <= 0, update the EMA (no reload), anchor <= raw, dwell_cnt <= 1, go to TRACK.
- Arithmetic:
  - diff is 11-bit signed (raw - filt). The shift is arithmetic, so it floors toward -inf.
  - The result always lies between the old filt and raw, so it never leaves range.
  - Steady-state lag below 2^FILT_SHIFT is accepted.
  - Abs-diff for the dwell test uses 11-bit signed values.
- Counter widths: dwell_cnt and miss_cnt are sized by $clog2(param+1). They saturate and never wrap.

Decomposition:
- Shared package holds:
  - state enum (IDLE/TRACK/STAMPED/COAST)
  - NOT_FOUND = 32'hFFFFFFFF
  - default frame dimensions 640/480
- One sub-module, track_ema: per-axis filter register.
  - Parameters: WIDTH, SHIFT.
  - Inputs: load, update, raw. Output: filt.
  - Instantiated twice, once for x and once for y.
- FSM, counters and anchor live in the top.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 and state=0 immediately; strobes during reset give no out_valid.
- First hit then filter: strobe (100,200) -> next cycle out_valid=1, present=1, x_filt=100, y_filt=200, state=1. Then strobe (120,200) -> x_filt=105, y_filt=200.
- Dwell: 30 strobes at (300±3, 300±3) -> stamp=1 on the 30th out_valid only and state=2. 31st identical strobe -> stamp=0. Strobe (320,300) -> state=1, dwell restarts.
- Dropout tolerance: after tracking, 2 strobes of 32'hFFFFFFFF then (300,300) -> present stays 1, state 3 then 1, filter not reloaded.
- Loss: 3 consecutive misses (FFFFFFFF, x=700, y=480) -> present=0 and state=0 on the 3rd out_valid; x_filt/y_filt hold. Next hit reloads the filter directly.
- Reset mid-dwell: 20 stationary frames, reset, then 29 more -> no stamp; 30th after reset -> stamp.
